// File: rtl/sram_access_master_if.sv
// Command/response channels between a requester and sram_access_master.
// The requester drives cmd_* and rsp_ready; the block drives cmd_ready and rsp_*.
interface sram_access_master_if #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic [ADDR_W-1:0] rsp_addr;
  logic              rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_wdata, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_addr, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_wdata, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_addr, rsp_err
  );
endinterface

// File: rtl/sram_access_master.sv
// Initiator for the main SRAM port: turns read/write/dump/clear commands into
// registered SRAM cycles and returns data/status on a valid/ready response channel.
module sram_access_master #(
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned PROT_BASE = 13
) (
  input  logic                 clk,
  input  logic                 sys_rst,
  sram_access_master_if.slave  cmd_rsp,
  output logic                 busy,
  output logic [ADDR_W-1:0]    mem_address,
  output logic [DATA_W-1:0]    mem_data_in,
  output logic                 mem_write_enable,
  input  logic [DATA_W-1:0]    mem_data_out
);

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_DUMP  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  localparam logic [ADDR_W-1:0] PROT_A    = ADDR_W'(PROT_BASE);
  localparam logic [ADDR_W-1:0] LAST_A    = ADDR_W'(DEPTH - 1);
  localparam logic [DATA_W-1:0] CLR_COUNT = DATA_W'(DEPTH - PROT_BASE);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WR   = 3'd2,
    S_RSP  = 3'd3,
    S_CLR  = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              busy_q, busy_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic [ADDR_W-1:0] rsp_addr_q, rsp_addr_d;
  logic              rsp_err_q, rsp_err_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_din_q, mem_din_d;
  logic              mem_we_q, mem_we_d;

  logic accept_c;
  logic rsp_hs_c;
  logic last_c;
  logic wr_ok_c;

  assign accept_c = cmd_rsp.cmd_valid && cmd_ready_q;
  assign rsp_hs_c = rsp_valid_q && cmd_rsp.rsp_ready;
  assign last_c   = (ptr_q == LAST_A);
  assign wr_ok_c  = (cmd_rsp.cmd_addr >= PROT_A);

  // State register
  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          unique case (cmd_rsp.cmd_op)
            OP_READ:  state_d = S_RD;
            OP_WRITE: state_d = wr_ok_c ? S_WR : S_RSP;
            OP_DUMP:  state_d = S_RD;
            OP_CLEAR: state_d = S_CLR;
          endcase
        end
      end
      S_RD:  state_d = S_RSP;
      S_WR:  state_d = S_RSP;
      S_CLR: if (last_c) state_d = S_RSP;
      S_RSP: begin
        if (rsp_hs_c) begin
          state_d = (op_q == OP_DUMP && !last_c) ? S_RD : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and registered-output next values
  always_comb begin
    op_d        = op_q;
    ptr_d       = ptr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_addr_d  = rsp_addr_q;
    rsp_err_d   = rsp_err_q;
    mem_addr_d  = mem_addr_q;
    mem_din_d   = mem_din_q;
    mem_we_d    = 1'b0;
    cmd_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);

    unique case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          op_d    = cmd_rsp.cmd_op;
          ptr_d   = cmd_rsp.cmd_addr;
          wdata_d = cmd_rsp.cmd_wdata;
          unique case (cmd_rsp.cmd_op)
            OP_READ, OP_DUMP: mem_addr_d = cmd_rsp.cmd_addr;
            OP_WRITE: begin
              if (wr_ok_c) begin
                mem_addr_d = cmd_rsp.cmd_addr;
                mem_din_d  = cmd_rsp.cmd_wdata;
                mem_we_d   = 1'b1;
              end else begin
                // Protected target: reject without touching the SRAM
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b1;
                rsp_data_d  = cmd_rsp.cmd_wdata;
                rsp_addr_d  = cmd_rsp.cmd_addr;
              end
            end
            OP_CLEAR: begin
              ptr_d      = PROT_A;
              mem_addr_d = PROT_A;
              mem_din_d  = '0;
              mem_we_d   = 1'b1;
            end
          endcase
        end
      end
      S_RD: begin
        rsp_valid_d = 1'b1;
        rsp_data_d  = mem_data_out;
        rsp_addr_d  = ptr_q;
        rsp_err_d   = 1'b0;
      end
      S_WR: begin
        rsp_valid_d = 1'b1;
        rsp_data_d  = wdata_q;
        rsp_addr_d  = ptr_q;
        rsp_err_d   = 1'b0;
      end
      S_CLR: begin
        if (last_c) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = CLR_COUNT;
          rsp_addr_d  = PROT_A;
          rsp_err_d   = 1'b0;
        end else begin
          ptr_d      = ptr_q + ADDR_W'(1);
          mem_addr_d = ptr_q + ADDR_W'(1);
          mem_din_d  = '0;
          mem_we_d   = 1'b1;
        end
      end
      S_RSP: begin
        if (rsp_hs_c) begin
          rsp_valid_d = 1'b0;
          if (op_q == OP_DUMP && !last_c) begin
            ptr_d      = ptr_q + ADDR_W'(1);
            mem_addr_d = ptr_q + ADDR_W'(1);
          end
        end
      end
      default: ;
    endcase
  end

  // Output and context registers; reset kills the write strobe immediately
  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      op_q        <= '0;
      ptr_q       <= '0;
      wdata_q     <= '0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_addr_q  <= '0;
      rsp_err_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_din_q   <= '0;
      mem_we_q    <= 1'b0;
    end else begin
      op_q        <= op_d;
      ptr_q       <= ptr_d;
      wdata_q     <= wdata_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_addr_q  <= rsp_addr_d;
      rsp_err_q   <= rsp_err_d;
      mem_addr_q  <= mem_addr_d;
      mem_din_q   <= mem_din_d;
      mem_we_q    <= mem_we_d;
    end
  end

  assign cmd_rsp.cmd_ready = cmd_ready_q;
  assign cmd_rsp.rsp_valid = rsp_valid_q;
  assign cmd_rsp.rsp_data  = rsp_data_q;
  assign cmd_rsp.rsp_addr  = rsp_addr_q;
  assign cmd_rsp.rsp_err   = rsp_err_q;
  assign busy              = busy_q;
  assign mem_address       = mem_addr_q;
  assign mem_data_in       = mem_din_q;
  assign mem_write_enable  = mem_we_q;

endmodule

// File: tb/tb_sram_access_master.sv
// Directed + random bench for sram_access_master against a word-level memory
// model; an SRAM behavioural array sits on the mem_* port.
module tb_sram_access_master;
  localparam int unsigned ADDR_W    = 4;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned DEPTH     = 16;
  localparam int unsigned PROT_BASE = 13;

  logic clk = 1'b0;
  logic sys_rst = 1'b1;
  always #5 clk = ~clk;

  sram_access_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  logic              busy;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data_in;
  logic [DATA_W-1:0] mem_data_out;
  logic              mem_write_enable;

  sram_access_master #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .PROT_BASE(PROT_BASE)
  ) dut (
    .clk              (clk),
    .sys_rst          (sys_rst),
    .cmd_rsp          (bus.slave),
    .busy             (busy),
    .mem_address      (mem_address),
    .mem_data_in      (mem_data_in),
    .mem_write_enable (mem_write_enable),
    .mem_data_out     (mem_data_out)
  );

  // SRAM environment: combinational read, write on the clock edge
  logic [DATA_W-1:0] sram [DEPTH];
  assign mem_data_out = sram[mem_address];

  typedef struct {
    int unsigned addr;
    int unsigned data;
    int unsigned cyc;
  } wr_t;

  typedef struct {
    logic [DATA_W-1:0] d;
    logic [ADDR_W-1:0] a;
    logic              e;
  } rsp_t;

  wr_t         we_log[$];
  int unsigned cyc = 0;
  int unsigned prot_viol = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_write_enable === 1'b1) begin
      sram[mem_address] <= mem_data_in;
      we_log.push_back('{addr: 32'(mem_address), data: 32'(mem_data_in), cyc: cyc});
      if (32'(mem_address) < PROT_BASE) prot_viol <= prot_viol + 1;
    end
  end

  logic [DATA_W-1:0] ref_mem [DEPTH];
  int total = 0;
  int bad = 0;
  int stall_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Wait for a response, hold rsp_ready low for 'stall' cycles checking stability, then accept
  task automatic get_rsp(input int stall, output rsp_t r, output int lat, output bit ok);
    lat = 0;
    ok  = 1'b1;
    r   = '{d: '0, a: '0, e: 1'b0};
    while (bus.rsp_valid !== 1'b1) begin
      if (lat >= 40) begin
        chk("rsp_timeout", 32'(bus.rsp_valid), 32'd1);
        ok = 1'b0;
        return;
      end
      lat++;
      @(negedge clk);
    end
    r = '{d: bus.rsp_data, a: bus.rsp_addr, e: bus.rsp_err};
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("rsp_hold", {bus.rsp_valid, bus.rsp_err, bus.rsp_addr, bus.rsp_data}, {1'b1, r.e, r.a, r.d});
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
  endtask

  // Issue one command (called at a negedge) and check all of its effects against the model
  task automatic run_cmd(input logic [1:0] op, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] w);
    rsp_t exp_q[$];
    wr_t  exp_w[$];
    int   lat0;
    int   n0;
    case (op)
      2'b00: exp_q.push_back('{d: ref_mem[a], a: a, e: 1'b0});
      2'b01: begin
        exp_q.push_back('{d: w, a: a, e: (32'(a) < PROT_BASE)});
        if (32'(a) >= PROT_BASE) begin
          ref_mem[a] = w;
          exp_w.push_back('{addr: 32'(a), data: 32'(w), cyc: 0});
        end
      end
      2'b10: for (int i = int'(a); i < int'(DEPTH); i++)
        exp_q.push_back('{d: ref_mem[i], a: ADDR_W'(i), e: 1'b0});
      default: begin
        for (int i = int'(PROT_BASE); i < int'(DEPTH); i++) begin
          ref_mem[i] = '0;
          exp_w.push_back('{addr: i, data: 0, cyc: 0});
        end
        exp_q.push_back('{d: DATA_W'(DEPTH - PROT_BASE), a: ADDR_W'(PROT_BASE), e: 1'b0});
      end
    endcase
    if (op == 2'b11)                                lat0 = int'(DEPTH - PROT_BASE);
    else if (op == 2'b01 && 32'(a) < PROT_BASE)     lat0 = 0;
    else                                            lat0 = 1;

    for (int i = 0; bus.cmd_ready !== 1'b1; i++) begin
      if (i >= 40) begin
        chk("cmd_ready_timeout", 32'(bus.cmd_ready), 32'd1);
        return;
      end
      @(negedge clk);
    end
    n0 = we_log.size();
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_addr  = a;
    bus.cmd_wdata = w;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'($urandom_range(0, 3));
    bus.cmd_addr  = ADDR_W'($urandom_range(0, DEPTH - 1));
    chk("busy_after_accept", {bus.cmd_ready, busy}, 2'b01);

    foreach (exp_q[k]) begin
      int   st;
      int   lat;
      bit   ok;
      rsp_t r;
      st = (stall_q.size() > 0) ? stall_q.pop_front() : int'($urandom_range(0, 2));
      get_rsp(st, r, lat, ok);
      if (!ok) return;
      chk(k == 0 ? "rsp_latency" : "dump_latency", lat, k == 0 ? lat0 : 1);
      chk("rsp_data", r.d, exp_q[k].d);
      chk("rsp_addr", r.a, exp_q[k].a);
      chk("rsp_err", r.e, exp_q[k].e);
    end
    chk("idle_after", {bus.cmd_ready, busy, bus.rsp_valid}, 3'b100);
    chk("we_count", we_log.size() - n0, exp_w.size());
    if (we_log.size() - n0 == exp_w.size()) begin
      foreach (exp_w[k]) begin
        chk("we_addr", we_log[n0 + k].addr, exp_w[k].addr);
        chk("we_data", we_log[n0 + k].data, exp_w[k].data);
        if (k > 0) chk("we_consecutive", we_log[n0 + k].cyc - we_log[n0 + k - 1].cyc, 1);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      ref_mem[i] = DATA_W'($urandom);
      sram[i]   <= ref_mem[i];
    end
    repeat (3) @(negedge clk);
    sys_rst = 1'b0;
    @(negedge clk);
    chk("reset_state", {bus.cmd_ready, busy, bus.rsp_valid, bus.rsp_err, mem_write_enable},
        5'b10000);
    chk("reset_rsp", {bus.rsp_data, bus.rsp_addr, mem_address}, '0);

    // Single read, then write/read-back above the protected region
    stall_q = {0};
    run_cmd(2'b00, 4'd3, 8'h00);
    run_cmd(2'b01, 4'd14, 8'hA5);
    run_cmd(2'b00, 4'd14, 8'h00);

    // Protected write is rejected and leaves the preload untouched
    run_cmd(2'b01, 4'd5, 8'hFF);
    run_cmd(2'b00, 4'd5, 8'h00);

    // Dump to the last address with back-pressure
    stall_q = {0, 2, 0, 1};
    run_cmd(2'b10, 4'd12, 8'h00);
    run_cmd(2'b10, 4'd15, 8'h00);

    // Clear the writable region, then dump it
    run_cmd(2'b01, 4'd13, 8'h11);
    run_cmd(2'b01, 4'd14, 8'h22);
    run_cmd(2'b01, 4'd15, 8'h33);
    run_cmd(2'b11, 4'd0, 8'h00);
    run_cmd(2'b10, 4'd13, 8'h00);

    // Random command mix
    for (int n = 0; n < 40; n++) begin
      int unsigned r;
      logic [1:0] op;
      logic [ADDR_W-1:0] a;
      r = $urandom_range(0, 9);
      op = (r < 4) ? 2'b00 : (r < 7) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      a = ($urandom_range(0, 1) == 1) ? ADDR_W'($urandom_range(PROT_BASE, DEPTH - 1))
                                      : ADDR_W'($urandom_range(0, DEPTH - 1));
      run_cmd(op, a, DATA_W'($urandom));
    end

    // Reset in the middle of a clear: strobe drops at once, remaining words untouched
    run_cmd(2'b01, 4'd14, 8'h66);
    run_cmd(2'b01, 4'd15, 8'h77);
    n0 = we_log.size();
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'b11;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    chk("clr_first_addr", {mem_write_enable, mem_address}, {1'b1, 4'd13});
    @(negedge clk);
    chk("clr_second_addr", {mem_write_enable, mem_address}, {1'b1, 4'd14});
    #1 sys_rst = 1'b1;
    #1;
    chk("rst_we_async", mem_write_enable, 1'b0);
    chk("rst_outputs", {bus.rsp_valid, bus.cmd_ready, busy}, 3'b010);
    @(negedge clk);
    sys_rst = 1'b0;
    @(negedge clk);
    ref_mem[13] = '0;
    chk("rst_we_count", we_log.size() - n0, 1);
    chk("rst_sram13", sram[13], 8'h00);
    chk("rst_sram14", sram[14], 8'h66);
    chk("rst_sram15", sram[15], 8'h77);
    run_cmd(2'b10, 4'd13, 8'h00);

    chk("prot_violations", prot_viol, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
